// File: rtl/dps_codec_02_pkg.sv
// rtl/dps_codec_02_pkg.sv - shared width constant and Gray code helpers for the DPS TSV codec
package dps_codec_02_pkg;

    localparam int DBLEN02 = 2;
    localparam int GRAY_W  = 32;

    function automatic logic [GRAY_W-1:0] gray_enc(input logic [GRAY_W-1:0] d);
        return d ^ (d >> 1);
    endfunction

    // Zero-extended codes decode identically in their low bits, so one width serves all DBLEN.
    function automatic logic [GRAY_W-1:0] gray_dec(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] d;
        d[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            d[i] = d[i+1] ^ g[i];
        end
        return d;
    endfunction

endpackage

// File: rtl/dps_decoder_core.sv
// rtl/dps_decoder_core.sv - combinational prefix-XOR Gray decoder for the TSV wires
module dps_decoder_core
    import dps_codec_02_pkg::*;
#(
    parameter int DBLEN = DBLEN02
) (
    input  logic [DBLEN-1:0] tsv,
    output logic [DBLEN-1:0] dataout
);

    // Unpacked chain keeps each prefix bit a distinct net for the XOR ripple.
    logic prefix [DBLEN];

    assign prefix[DBLEN-1] = tsv[DBLEN-1];

    for (genvar i = 0; i < DBLEN - 1; i++) begin : g_prefix
        assign prefix[i] = prefix[i+1] ^ tsv[i];
    end

    for (genvar i = 0; i < DBLEN; i++) begin : g_out
        assign dataout[i] = prefix[i];
    end

endmodule

// File: rtl/dps_encoder_core.sv
// rtl/dps_encoder_core.sv - registered Gray encoder driving the TSV wires
module dps_encoder_core
    import dps_codec_02_pkg::*;
#(
    parameter int DBLEN = DBLEN02
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DBLEN-1:0] datain,
    output logic [DBLEN-1:0] tsv
);

    logic [GRAY_W-1:0] code;

    assign code = gray_enc(GRAY_W'(datain));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tsv <= '0;
        end else begin
            tsv <= code[DBLEN-1:0];
        end
    end

endmodule

// File: rtl/dps_codec_02.sv
// rtl/dps_codec_02.sv - DPS TSV link codec: registered Gray encoder feeding a combinational decoder
module dps_codec_02
    import dps_codec_02_pkg::*;
#(
    parameter int DBLEN = DBLEN02
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DBLEN-1:0] datain,
    output logic [DBLEN-1:0] tsv,
    output logic [DBLEN-1:0] dataout
);

    logic [DBLEN-1:0] tsv_bus;

    dps_encoder_core #(.DBLEN(DBLEN)) u_enc (
        .clock  (clock),
        .reset  (reset),
        .datain (datain),
        .tsv    (tsv_bus)
    );

    dps_decoder_core #(.DBLEN(DBLEN)) u_dec (
        .tsv     (tsv_bus),
        .dataout (dataout)
    );

    assign tsv = tsv_bus;

endmodule

// File: tb/tb_dps_codec_02.sv
// tb/tb_dps_codec_02.sv - scoreboard bench for dps_codec_02 with a reflected-binary reference table
module tb_dps_codec_02;

    localparam int W = 2;
    localparam int N = 1 << W;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] datain;
    logic [W-1:0] tsv;
    logic [W-1:0] dataout;
    logic [W-1:0] dec_in;
    logic [W-1:0] dec_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int    tsv_e;
        int    data_e;
        string tag;
    } exp_t;

    exp_t sbq[$];
    int   gray_tab[N];

    dps_codec_02 #(.DBLEN(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .datain  (datain),
        .tsv     (tsv),
        .dataout (dataout)
    );

    dps_decoder_core #(.DBLEN(W)) dec_only (
        .tsv     (dec_in),
        .dataout (dec_out)
    );

    always #5 clock = ~clock;

    // Reflected construction: append the mirrored list with the next bit set.
    function automatic void build_table();
        int n;
        n = 1;
        gray_tab[0] = 0;
        for (int k = 0; k < W; k++) begin
            for (int j = 0; j < n; j++) begin
                gray_tab[n + j] = gray_tab[n - 1 - j] | (1 << k);
            end
            n = n * 2;
        end
    endfunction

    function automatic int decode_ref(input int code);
        for (int i = 0; i < N; i++) begin
            if (gray_tab[i] == code) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic send(input int v, input bit in_reset, input string tag);
        exp_t e;
        int   t;
        @(negedge clock);
        datain = W'(v);
        t = v % N;
        e.tsv_e  = in_reset ? 0 : gray_tab[t];
        e.data_e = in_reset ? 0 : t;
        e.tag    = tag;
        sbq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk({e.tag, "_tsv"}, int'(tsv), e.tsv_e);
                chk({e.tag, "_dataout"}, int'(dataout), e.data_e);
            end
        end
    end

    initial begin : stim
        build_table();
        reset  = 1'b1;
        datain = 3;
        dec_in = '0;
        #1;
        chk("reset_imm_tsv", int'(tsv), 0);
        chk("reset_imm_dataout", int'(dataout), 0);
        repeat (3) send(3, 1'b1, "reset");

        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("deassert_no_edge_tsv", int'(tsv), 0);

        for (int v = 0; v < N; v++) send(v, 1'b0, "sweep");

        send(2, 1'b0, "hold_load");
        @(posedge clock);
        #3;
        datain = 1;
        #1;
        chk("hold_tsv", int'(tsv), gray_tab[2]);
        chk("hold_dataout", int'(dataout), 2);

        send(3, 1'b0, "pre_reset");
        @(posedge clock);
        #3;
        reset = 1'b1;
        #0.5;
        chk("async_tsv", int'(tsv), 0);
        chk("async_dataout", int'(dataout), 0);
        reset = 1'b0;
        #0.5;
        chk("async_release_tsv", int'(tsv), 0);
        send(1, 1'b0, "post_reset");

        for (int i = 0; i < 1000; i++) send(int'($urandom % 10), 1'b0, "rand");

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clock);
        #3;
        chk("drain", sbq.size(), 0);

        for (int c = 0; c < N; c++) begin
            dec_in = W'(c);
            #1;
            chk("dec_only", int'(dec_out), decode_ref(c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
